// File: rtl/object_marker_overlay.sv
// Multi-object marker overlay for a VGA pixel stream: per-object coloured squares, boxes or crosshairs,
// with frame-shadowed object data, optional frame-synchronous blink and a fixed 2-cycle pipeline.
`timescale 1ns/1ps
module object_marker_overlay #(
   parameter int unsigned COLOR_WIDTH  = 10,
   parameter int unsigned DISP_WIDTH   = 11,
   parameter int unsigned NUM_OBJ      = 4,
   parameter int unsigned SIZE_WIDTH   = 6,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic                               clk,
   input  logic                               areset,
   input  logic                               in_valid,
   input  logic [COLOR_WIDTH-1:0]             red,
   input  logic [COLOR_WIDTH-1:0]             green,
   input  logic [COLOR_WIDTH-1:0]             blue,
   input  logic [DISP_WIDTH-1:0]              x_pos,
   input  logic [DISP_WIDTH-1:0]              y_pos,
   input  logic                               frame_start,
   input  logic [NUM_OBJ-1:0]                 obj_valid,
   input  logic [NUM_OBJ*DISP_WIDTH-1:0]      x_obj,
   input  logic [NUM_OBJ*DISP_WIDTH-1:0]      y_obj,
   input  logic [NUM_OBJ*3*COLOR_WIDTH-1:0]   obj_rgb,
   input  logic [SIZE_WIDTH-1:0]              half_size,
   input  logic [1:0]                         mode,
   input  logic                               blink_en,
   output logic                               out_valid,
   output logic [COLOR_WIDTH-1:0]             r_out,
   output logic [COLOR_WIDTH-1:0]             g_out,
   output logic [COLOR_WIDTH-1:0]             b_out
);

   localparam int unsigned RGB_W = 3 * COLOR_WIDTH;
   localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef enum logic [1:0] {
      MODE_FILLED  = 2'd0,
      MODE_OUTLINE = 2'd1,
      MODE_CROSS   = 2'd2,
      MODE_OFF     = 2'd3
   } mode_e;

   logic [NUM_OBJ-1:0]            sh_valid_q, sh_valid_d;
   logic [NUM_OBJ*DISP_WIDTH-1:0] sh_x_q, sh_x_d;
   logic [NUM_OBJ*DISP_WIDTH-1:0] sh_y_q, sh_y_d;
   logic [NUM_OBJ*RGB_W-1:0]      sh_rgb_q, sh_rgb_d;
   logic [CNT_W-1:0]              frame_cnt_q, frame_cnt_d;
   logic                          phase_q, phase_d;

   logic                          s1_valid_q, s1_valid_d;
   logic [RGB_W-1:0]              s1_rgb_q, s1_rgb_d;
   logic [NUM_OBJ-1:0]            s1_hit_q, s1_hit_d;
   logic [RGB_W-1:0]              s1_mark_q, s1_mark_d;
   logic                          out_valid_q, out_valid_d;
   logic [RGB_W-1:0]              out_rgb_q, out_rgb_d;

   logic [DISP_WIDTH-1:0]         dx [NUM_OBJ];
   logic [DISP_WIDTH-1:0]         dy [NUM_OBJ];
   logic [NUM_OBJ-1:0]            in_box, on_edge, on_cross, shape_hit;
   logic [DISP_WIDTH-1:0]         size_ext;
   logic                          visible;
   logic                          found;
   mode_e                         mode_sel;

   assign size_ext = DISP_WIDTH'(half_size);
   assign visible  = ~blink_en | phase_q;
   assign mode_sel = mode_e'(mode);

   always_comb begin : frame_ctrl
      sh_valid_d  = sh_valid_q;
      sh_x_d      = sh_x_q;
      sh_y_d      = sh_y_q;
      sh_rgb_d    = sh_rgb_q;
      frame_cnt_d = frame_cnt_q;
      phase_d     = phase_q;
      if (frame_start) begin
         sh_valid_d = obj_valid;
         sh_x_d     = x_obj;
         sh_y_d     = y_obj;
         sh_rgb_d   = obj_rgb;
         if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            frame_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin : geometry
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
         dx[i] = (x_pos >= sh_x_q[i*DISP_WIDTH +: DISP_WIDTH])
               ? x_pos - sh_x_q[i*DISP_WIDTH +: DISP_WIDTH]
               : sh_x_q[i*DISP_WIDTH +: DISP_WIDTH] - x_pos;
         dy[i] = (y_pos >= sh_y_q[i*DISP_WIDTH +: DISP_WIDTH])
               ? y_pos - sh_y_q[i*DISP_WIDTH +: DISP_WIDTH]
               : sh_y_q[i*DISP_WIDTH +: DISP_WIDTH] - y_pos;
         in_box[i]   = (dx[i] <= size_ext) && (dy[i] <= size_ext);
         on_edge[i]  = (dx[i] == size_ext) || (dy[i] == size_ext);
         on_cross[i] = ((dx[i] == '0) && (dy[i] <= size_ext)) ||
                       ((dy[i] == '0) && (dx[i] <= size_ext));
         shape_hit[i] = 1'b0;
         case (mode_sel)
            MODE_FILLED:  shape_hit[i] = in_box[i];
            MODE_OUTLINE: shape_hit[i] = in_box[i] & on_edge[i];
            MODE_CROSS:   shape_hit[i] = on_cross[i];
            MODE_OFF:     shape_hit[i] = 1'b0;
         endcase
      end
   end

   // The marker colour is latched alongside the hit vector so a frame_start on the
   // capture edge cannot swap in the next frame's colour before stage 2 uses it.
   always_comb begin : stage1
      s1_valid_d = in_valid;
      s1_rgb_d   = {red, green, blue};
      s1_hit_d   = shape_hit & sh_valid_q & {NUM_OBJ{visible}};
      s1_mark_d  = '0;
      found      = 1'b0;
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
         if (s1_hit_d[i] && !found) begin
            s1_mark_d = sh_rgb_q[i*RGB_W +: RGB_W];
            found     = 1'b1;
         end
      end
   end

   always_comb begin : stage2
      out_valid_d = s1_valid_q;
      out_rgb_d   = (|s1_hit_q) ? s1_mark_q : s1_rgb_q;
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         sh_valid_q  <= '0;
         sh_x_q      <= '0;
         sh_y_q      <= '0;
         sh_rgb_q    <= '0;
         frame_cnt_q <= '0;
         phase_q     <= 1'b1;
         s1_valid_q  <= 1'b0;
         s1_rgb_q    <= '0;
         s1_hit_q    <= '0;
         s1_mark_q   <= '0;
         out_valid_q <= 1'b0;
         out_rgb_q   <= '0;
      end else begin
         sh_valid_q  <= sh_valid_d;
         sh_x_q      <= sh_x_d;
         sh_y_q      <= sh_y_d;
         sh_rgb_q    <= sh_rgb_d;
         frame_cnt_q <= frame_cnt_d;
         phase_q     <= phase_d;
         s1_valid_q  <= s1_valid_d;
         s1_rgb_q    <= s1_rgb_d;
         s1_hit_q    <= s1_hit_d;
         s1_mark_q   <= s1_mark_d;
         out_valid_q <= out_valid_d;
         out_rgb_q   <= out_rgb_d;
      end
   end

   assign out_valid              = out_valid_q;
   assign {r_out, g_out, b_out}  = out_rgb_q;

endmodule

// File: tb/tb_object_marker_overlay.sv
// Scoreboard bench for object_marker_overlay: expected pixels are queued as they are driven
// and matched (colour and arrival cycle) when out_valid appears.
`timescale 1ns/1ps
module tb_object_marker_overlay;

   localparam int CW = 10;
   localparam int DW = 11;
   localparam int NO = 4;

   logic              clk = 1'b0;
   logic              areset;
   logic              in_valid;
   logic [CW-1:0]     red, green, blue;
   logic [DW-1:0]     x_pos, y_pos;
   logic              frame_start;
   logic [NO-1:0]     obj_valid;
   logic [NO*DW-1:0]  x_obj, y_obj;
   logic [NO*3*CW-1:0] obj_rgb;
   logic [5:0]        half_size;
   logic [1:0]        mode;
   logic              blink_en;
   logic              out_valid;
   logic [CW-1:0]     r_out, g_out, b_out;

   typedef struct {
      logic [29:0] rgb;
      int          cyc;
      string       tag;
   } sb_entry_t;

   sb_entry_t sb[$];
   int        cyc = 0;
   int        n_checks = 0;
   int        n_pass = 0;

   localparam logic [29:0] RED   = {10'h3FF, 10'h000, 10'h000};
   localparam logic [29:0] GREEN = {10'h000, 10'h3FF, 10'h000};
   localparam logic [29:0] BLUE  = {10'h000, 10'h000, 10'h3FF};

   object_marker_overlay #(
      .COLOR_WIDTH (CW),
      .DISP_WIDTH  (DW),
      .NUM_OBJ     (NO),
      .SIZE_WIDTH  (6),
      .BLINK_FRAMES(2)
   ) dut (
      .clk        (clk),
      .areset     (areset),
      .in_valid   (in_valid),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .x_pos      (x_pos),
      .y_pos      (y_pos),
      .frame_start(frame_start),
      .obj_valid  (obj_valid),
      .x_obj      (x_obj),
      .y_obj      (y_obj),
      .obj_rgb    (obj_rgb),
      .half_size  (half_size),
      .mode       (mode),
      .blink_en   (blink_en),
      .out_valid  (out_valid),
      .r_out      (r_out),
      .g_out      (g_out),
      .b_out      (b_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [29:0] rgb_of(input int x, input int y);
      return {10'(x), 10'h155, 10'(y)};
   endfunction

   task automatic set_obj(input int i, input int x, input int y, input logic [29:0] c);
      x_obj[i*DW +: DW]   = 11'(x);
      y_obj[i*DW +: DW]   = 11'(y);
      obj_rgb[i*30 +: 30] = c;
   endtask

   task automatic drive_pixel(input int x, input int y, input logic [1:0] md, input int sz,
                              input logic [29:0] exp, input string tag, input bit fs = 1'b0);
      sb_entry_t e;
      @(negedge clk);
      in_valid            = 1'b1;
      x_pos               = 11'(x);
      y_pos               = 11'(y);
      {red, green, blue}  = rgb_of(x, y);
      mode                = md;
      half_size           = 6'(sz);
      frame_start         = fs;
      e.rgb = exp;
      e.cyc = cyc + 2;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid    = 1'b0;
         frame_start = 1'b0;
      end
   endtask

   task automatic pulse_frame();
      @(negedge clk);
      in_valid    = 1'b0;
      frame_start = 1'b1;
   endtask

   task automatic monitor_loop();
      sb_entry_t e;
      forever begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
               $display("FAIL unexpected_out: out_valid=1 rgb=%h with nothing expected at cycle %0d",
                        {r_out, g_out, b_out}, cyc);
            end else begin
               e = sb.pop_front();
               if ({r_out, g_out, b_out} !== e.rgb || cyc !== e.cyc)
                  $display("FAIL %s: got rgb=%h at cycle %0d, expected rgb=%h at cycle %0d",
                           e.tag, {r_out, g_out, b_out}, cyc, e.rgb, e.cyc);
               else
                  n_pass++;
            end
         end
      end
   endtask

   task automatic test_reset();
      areset = 1'b1;
      in_valid = 1'b0; frame_start = 1'b0; blink_en = 1'b0;
      red = '0; green = '0; blue = '0; x_pos = '0; y_pos = '0;
      obj_valid = '0; x_obj = '0; y_obj = '0; obj_rgb = '0;
      half_size = '0; mode = 2'd0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_valid: out_valid=%b expected 0", out_valid);
      else n_pass++;
      n_checks++;
      if ({r_out, g_out, b_out} !== 30'd0) $display("FAIL reset_rgb: rgb=%h expected 0", {r_out, g_out, b_out});
      else n_pass++;
      areset = 1'b0;
   endtask

   task automatic test_passthrough();
      obj_valid = 4'hF;
      set_obj(0, 10, 10, RED);
      set_obj(1, 12, 10, GREEN);
      set_obj(2, 14, 10, BLUE);
      set_obj(3, 16, 10, RED);
      for (int x = 8; x < 18; x++)
         drive_pixel(x, 10, 2'd0, 5, rgb_of(x, 10), "pass_noframe");
      idle(1);
      drive_pixel(10, 10, 2'd2, 0, rgb_of(10, 10), "pass_after_gap");
      idle(4);
   endtask

   task automatic test_filled();
      obj_valid = 4'b0001;
      set_obj(0, 100, 50, RED);
      pulse_frame();
      for (int x = 97; x <= 103; x++)
         drive_pixel(x, 50, 2'd0, 2, (x >= 98 && x <= 102) ? RED : rgb_of(x, 50), "filled_scan");
      drive_pixel(100, 52, 2'd0, 2, RED,              "filled_dy_edge");
      drive_pixel(100, 53, 2'd0, 2, rgb_of(100, 53),  "filled_dy_out");
      drive_pixel(100, 50, 2'd0, 0, RED,              "filled_s0_centre");
      drive_pixel(101, 50, 2'd0, 0, rgb_of(101, 50),  "filled_s0_side");
      drive_pixel(100, 50, 2'd1, 0, RED,              "outline_s0_centre");
      drive_pixel(100, 50, 2'd2, 0, RED,              "cross_s0_centre");
      drive_pixel(100, 50, 2'd3, 5, rgb_of(100, 50),  "mode_off");
      idle(4);
   endtask

   task automatic test_outline_cross();
      drive_pixel(103, 50, 2'd1, 3, RED,             "outline_right");
      drive_pixel(100, 47, 2'd1, 3, RED,             "outline_top");
      drive_pixel(101, 49, 2'd1, 3, rgb_of(101, 49), "outline_inner");
      drive_pixel(97,  53, 2'd1, 3, RED,             "outline_corner");
      drive_pixel(100, 53, 2'd2, 3, RED,             "cross_vert");
      drive_pixel(97,  50, 2'd2, 3, RED,             "cross_left");
      drive_pixel(101, 51, 2'd2, 3, rgb_of(101, 51), "cross_diag");
      drive_pixel(104, 50, 2'd2, 3, rgb_of(104, 50), "cross_beyond");
      idle(4);
   endtask

   task automatic test_priority();
      obj_valid = 4'b0011;
      set_obj(0, 200, 200, RED);
      set_obj(1, 200, 200, GREEN);
      pulse_frame();
      drive_pixel(200, 200, 2'd0, 1, RED, "prio_obj0");
      drive_pixel(201, 200, 2'd0, 1, RED, "prio_obj0_edge");
      obj_valid = 4'b0010;
      set_obj(0, 200, 200, BLUE);
      drive_pixel(200, 200, 2'd0, 1, RED,   "prio_fs_same_edge", 1'b1);
      drive_pixel(200, 200, 2'd0, 1, GREEN, "prio_obj1_after");
      drive_pixel(201, 201, 2'd0, 1, GREEN, "prio_obj1_corner");
      drive_pixel(202, 200, 2'd0, 1, rgb_of(202, 200), "prio_outside");
      idle(4);
   endtask

   task automatic test_blink();
      bit [1:8] vis = 8'b1001_1001;
      @(negedge clk);
      areset = 1'b1;
      @(negedge clk);
      areset = 1'b0;
      obj_valid = 4'b0001;
      set_obj(0, 100, 50, RED);
      blink_en = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         pulse_frame();
         drive_pixel(100, 50, 2'd0, 2, vis[k] ? RED : rgb_of(100, 50), $sformatf("blink_frame%0d", k));
      end
      blink_en = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         pulse_frame();
         drive_pixel(101, 50, 2'd0, 2, RED, $sformatf("noblink_frame%0d", k));
      end
      idle(4);
   endtask

   task automatic test_midstream_reset();
      drive_pixel(100, 50, 2'd0, 2, RED,             "pre_reset_a");
      drive_pixel(90,  50, 2'd0, 2, rgb_of(90, 50),  "pre_reset_b");
      drive_pixel(100, 51, 2'd0, 2, RED,             "pre_reset_c");
      #2;
      areset = 1'b1;
      #1;
      sb.delete();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL midreset_valid: out_valid=%b expected 0", out_valid);
      else n_pass++;
      n_checks++;
      if ({r_out, g_out, b_out} !== 30'd0) $display("FAIL midreset_rgb: rgb=%h expected 0", {r_out, g_out, b_out});
      else n_pass++;
      repeat (2) @(negedge clk);
      areset   = 1'b0;
      in_valid = 1'b0;
      idle(3);
      obj_valid = 4'hF;
      drive_pixel(100, 50, 2'd0, 2, rgb_of(100, 50), "post_reset_no_marker");
      drive_pixel(101, 50, 2'd2, 3, rgb_of(101, 50), "post_reset_cross");
      idle(5);
   endtask

   initial begin
      fork
         monitor_loop();
      join_none
      test_reset();
      test_passthrough();
      test_filled();
      test_outline_cross();
      test_priority();
      test_blink();
      test_midstream_reset();
      n_checks++;
      if (sb.size() != 0) $display("FAIL drain: %0d expected pixels never emerged, 0 required", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
